// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer RAM arbiter between the screen flasher (reader) and
// the draw engine (writer). Reads win by default; a starvation counter bounds writer wait.
`ifndef MEMORY_SIZE_BITS
`define MEMORY_SIZE_BITS 15
`endif
`ifndef COLOR_SIZE
`define COLOR_SIZE 3
`endif

module fb_port_arbiter #(
    parameter int ADDR_W       = `MEMORY_SIZE_BITS,
    parameter int COLOR_W      = `COLOR_SIZE,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               Clck,
    input  logic               Reset,
    input  logic               fl_req,
    input  logic [ADDR_W-1:0]  fl_addr,
    output logic               fl_gnt,
    output logic [COLOR_W-1:0] fl_rdata,
    output logic               fl_rvalid,
    input  logic               wr_req,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    output logic               wr_gnt,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_wdata,
    output logic               mem_we,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic [3:0]         starve_cnt
);

    localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
    localparam logic [3:0] CNT_MAX = 4'd15;

    logic [3:0] starve_q;
    logic [3:0] starve_d;
    logic       rvalid_q;
    logic       rvalid_d;
    logic       fl_gnt_s;
    logic       wr_gnt_s;

    // Grant selection: writer wins only when alone or once it has starved long enough.
    always_comb begin
        fl_gnt_s = 1'b0;
        wr_gnt_s = 1'b0;
        if (Reset) begin
            fl_gnt_s = 1'b0;
            wr_gnt_s = 1'b0;
        end else if (wr_req && (!fl_req || (starve_q >= LIMIT))) begin
            wr_gnt_s = 1'b1;
        end else if (fl_req) begin
            fl_gnt_s = 1'b1;
        end else begin
            fl_gnt_s = 1'b0;
            wr_gnt_s = 1'b0;
        end
    end

    // Next-state for the starvation counter and the read-valid strobe.
    always_comb begin
        starve_d = 4'd0;
        rvalid_d = fl_gnt_s;
        if (!wr_req || wr_gnt_s) begin
            starve_d = 4'd0;
        end else if (starve_q == CNT_MAX) begin
            starve_d = CNT_MAX;
        end else begin
            starve_d = starve_q + 4'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clck) begin
        if (Reset) begin
            starve_q <= 4'd0;
            rvalid_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign fl_gnt     = fl_gnt_s;
    assign wr_gnt     = wr_gnt_s;
    assign mem_addr   = wr_gnt_s ? wr_addr : fl_addr;
    assign mem_wdata  = wr_data;
    assign mem_we     = wr_gnt_s;
    // A read granted just before reset is dropped rather than reported.
    assign fl_rvalid  = rvalid_q & ~Reset;
    assign fl_rdata   = mem_rdata;
    assign starve_cnt = starve_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed table plus hand sequences and a random soak for fb_port_arbiter,
// with a behavioural synchronous RAM attached to the memory port.
module tb_fb_port_arbiter;

    localparam int AW    = 15;
    localparam int CW    = 3;
    localparam int LIMIT = 4;

    logic          Clck = 1'b0;
    logic          Reset;
    logic          fl_req;
    logic [AW-1:0] fl_addr;
    logic          fl_gnt;
    logic [CW-1:0] fl_rdata;
    logic          fl_rvalid;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic          wr_gnt;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_wdata;
    logic          mem_we;
    logic [CW-1:0] mem_rdata;
    logic [3:0]    starve_cnt;

    logic          preload;
    logic [CW-1:0] ram [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    fb_port_arbiter #(.ADDR_W(AW), .COLOR_W(CW), .STARVE_LIMIT(LIMIT)) dut (
        .Clck(Clck), .Reset(Reset),
        .fl_req(fl_req), .fl_addr(fl_addr), .fl_gnt(fl_gnt),
        .fl_rdata(fl_rdata), .fl_rvalid(fl_rvalid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
    );

    always #5 Clck = ~Clck;

    always @(posedge Clck) begin
        if (preload) begin
            ram[15'h012C] <= 3'b101;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic          rst, fl, wr;
        logic [AW-1:0] fa, wa;
        logic [CW-1:0] wd;
        logic          e_fg, e_wg, e_we;
        logic [AW-1:0] e_ma;
        logic [3:0]    e_sc;
        logic          e_rv, chk_rd;
        logic [CW-1:0] e_rd;
    } vec_t;

    vec_t vecs [0:63];
    int   nv = 0;

    task automatic add(input logic rst, fl, wr, input logic [AW-1:0] fa, wa,
                       input logic [CW-1:0] wd, input logic e_fg, e_wg, e_we,
                       input logic [AW-1:0] e_ma, input logic [3:0] e_sc,
                       input logic e_rv, chk_rd, input logic [CW-1:0] e_rd);
        vecs[nv] = '{rst, fl, wr, fa, wa, wd, e_fg, e_wg, e_we, e_ma, e_sc, e_rv, chk_rd, e_rd};
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_row(input logic [3:0] sc, input logic rv, input logic chk_rd,
                            input logic [CW-1:0] rd);
        add(1'b0, 1'b0, 1'b0, 15'h0000, 15'h0000, 3'b000,
            1'b0, 1'b0, 1'b0, 15'h0000, sc, rv, chk_rd, rd);
    endtask

    logic       m_fg, m_wg, m_prev_fg;
    logic [3:0] m_sc;
    int         m_wait;

    initial begin
        Reset = 1'b1; preload = 1'b1;
        fl_req = 1'b1; wr_req = 1'b1;
        fl_addr = 15'h0000; wr_addr = 15'h7FFF; wr_data = 3'b011;

        // Reset held with both requests high.
        for (int i = 0; i < 3; i++)
            add(1'b1, 1'b1, 1'b1, 15'h0000, 15'h7FFF, 3'b011,
                1'b0, 1'b0, 1'b0, 15'h0000, 4'd0, 1'b0, 1'b0, 3'b000);
        // Both held after release: flasher x4, writer, flasher x4, writer, flasher x2.
        for (int c = 0; c < 12; c++) begin
            logic w;
            logic [3:0] sc;
            logic rv;
            w  = (c == 4) || (c == 9);
            sc = 4'(c % 5);
            rv = (c != 0) && (c != 5) && (c != 10);
            add(1'b0, 1'b1, 1'b1, 15'h0000, 15'h7FFF, 3'b011,
                !w, w, w, w ? 15'h7FFF : 15'h0000, sc, rv, 1'b0, 3'b000);
        end
        idle_row(4'd2, 1'b1, 1'b0, 3'b000);
        idle_row(4'd0, 1'b0, 1'b0, 3'b000);
        // Write 0x4AFF then read it back on the next cycle.
        add(1'b0, 1'b0, 1'b1, 15'h0000, 15'h4AFF, 3'b110,
            1'b0, 1'b1, 1'b1, 15'h4AFF, 4'd0, 1'b0, 1'b0, 3'b000);
        add(1'b0, 1'b1, 1'b0, 15'h4AFF, 15'h4AFF, 3'b110,
            1'b1, 1'b0, 1'b0, 15'h4AFF, 4'd0, 1'b0, 1'b0, 3'b000);
        idle_row(4'd0, 1'b1, 1'b1, 3'b110);
        // Writer loses once then drops its request.
        add(1'b0, 1'b1, 1'b1, 15'h4AFF, 15'h0001, 3'b101,
            1'b1, 1'b0, 1'b0, 15'h4AFF, 4'd0, 1'b0, 1'b0, 3'b000);
        idle_row(4'd1, 1'b1, 1'b1, 3'b110);
        // Top address read back, then preloaded 0x12C.
        add(1'b0, 1'b1, 1'b0, 15'h7FFF, 15'h0000, 3'b000,
            1'b1, 1'b0, 1'b0, 15'h7FFF, 4'd0, 1'b0, 1'b0, 3'b000);
        idle_row(4'd0, 1'b1, 1'b1, 3'b011);
        add(1'b0, 1'b1, 1'b0, 15'h012C, 15'h0000, 3'b000,
            1'b1, 1'b0, 1'b0, 15'h012C, 4'd0, 1'b0, 1'b0, 3'b000);
        idle_row(4'd0, 1'b1, 1'b1, 3'b101);

        repeat (2) @(posedge Clck);
        #1 preload = 1'b0;

        for (int i = 0; i < nv; i++) begin
            @(posedge Clck); #1;
            Reset = vecs[i].rst; fl_req = vecs[i].fl; wr_req = vecs[i].wr;
            fl_addr = vecs[i].fa; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            @(negedge Clck);
            chk($sformatf("v%0d fl_gnt", i), 32'(fl_gnt), 32'(vecs[i].e_fg));
            chk($sformatf("v%0d wr_gnt", i), 32'(wr_gnt), 32'(vecs[i].e_wg));
            chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_ma));
            chk($sformatf("v%0d starve_cnt", i), 32'(starve_cnt), 32'(vecs[i].e_sc));
            chk($sformatf("v%0d fl_rvalid", i), 32'(fl_rvalid), 32'(vecs[i].e_rv));
            if (vecs[i].e_we)
                chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].wd));
            if (vecs[i].chk_rd)
                chk($sformatf("v%0d fl_rdata", i), 32'(fl_rdata), 32'(vecs[i].e_rd));
        end

        // Reset arriving the cycle after a read grant drops the read.
        @(posedge Clck); #1;
        Reset = 1'b0; fl_req = 1'b1; fl_addr = 15'h012C; wr_req = 1'b0;
        @(negedge Clck);
        chk("midrst grant", 32'(fl_gnt), 32'd1);
        @(posedge Clck); #1;
        Reset = 1'b1;
        @(negedge Clck);
        chk("midrst rvalid N+1", 32'(fl_rvalid), 32'd0);
        chk("midrst gnt forced", 32'(fl_gnt), 32'd0);
        @(posedge Clck); #1;
        Reset = 1'b0; fl_req = 1'b0;
        @(negedge Clck);
        chk("midrst rvalid N+2", 32'(fl_rvalid), 32'd0);
        chk("midrst starve", 32'(starve_cnt), 32'd0);

        // Random soak against a reference model.
        m_sc = 4'd0; m_prev_fg = 1'b0; m_wait = 0; m_fg = 1'b0; m_wg = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge Clck); #1;
            if (!fl_req || m_fg) begin
                fl_req  = ($urandom_range(3) != 0);
                fl_addr = AW'($urandom);
            end else if ($urandom_range(15) == 0) begin
                fl_req = 1'b0;
            end
            if (!wr_req || m_wg) begin
                wr_req  = ($urandom_range(2) == 0);
                wr_addr = AW'($urandom);
                wr_data = CW'($urandom);
            end else if ($urandom_range(15) == 0) begin
                wr_req = 1'b0;
            end
            @(negedge Clck);
            m_wg = wr_req && (!fl_req || (m_sc >= 4'(LIMIT)));
            m_fg = fl_req && !m_wg;
            chk($sformatf("soak%0d fl_gnt", cyc), 32'(fl_gnt), 32'(m_fg));
            chk($sformatf("soak%0d wr_gnt", cyc), 32'(wr_gnt), 32'(m_wg));
            chk($sformatf("soak%0d one-hot", cyc), 32'(fl_gnt & wr_gnt), 32'd0);
            chk($sformatf("soak%0d starve", cyc), 32'(starve_cnt), 32'(m_sc));
            chk($sformatf("soak%0d rvalid", cyc), 32'(fl_rvalid), 32'(m_prev_fg));
            if (wr_req && !wr_gnt) begin
                m_wait++;
                chk($sformatf("soak%0d wait bound", cyc), 32'(m_wait <= LIMIT), 32'd1);
            end else begin
                m_wait = 0;
            end
            m_prev_fg = m_fg;
            if (!wr_req || m_wg) m_sc = 4'd0;
            else if (m_sc != 4'd15) m_sc = m_sc + 4'd1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
